// File: rtl/fm_envgen_mux_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fm_envgen_mux_if : config/key/strobe bus and attenuation output stream     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface fm_envgen_mux_if #(
    parameter int OP_W = 3
);
    logic            cfg_wr;
    logic [OP_W-1:0] cfg_op;
    logic [21:0]     cfg_data;
    logic            key_wr;
    logic [OP_W-1:0] key_op;
    logic            key_on;
    logic            sample_strobe;
    logic            busy;
    logic            att_valid;
    logic [OP_W-1:0] att_op;
    logic [8:0]      att_level;
    logic            overrun;

    modport master (
        output cfg_wr, cfg_op, cfg_data, key_wr, key_op, key_on, sample_strobe,
        input  busy, att_valid, att_op, att_level, overrun
    );

    modport slave (
        input  cfg_wr, cfg_op, cfg_data, key_wr, key_op, key_on, sample_strobe,
        output busy, att_valid, att_op, att_level, overrun
    );
endinterface
`default_nettype wire

// File: rtl/fm_envgen_mux.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fm_envgen_mux : time-multiplexed ADSR envelope generator, one op per clock |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module fm_envgen_mux #(
    parameter int NUM_OPS = 8,
    parameter int OP_W    = 3,
    parameter int CNT_W   = 15
) (
    input  wire logic      clk,
    input  wire logic      reset,
    fm_envgen_mux_if.slave bus
);
    typedef enum logic [2:0] {
        PH_IDLE    = 3'd0,
        PH_ATTACK  = 3'd1,
        PH_DECAY   = 3'd2,
        PH_SUSTAIN = 3'd3,
        PH_RELEASE = 3'd4
    } phase_t;

    typedef enum logic [0:0] {
        SW_IDLE = 1'b0,
        SW_RUN  = 1'b1
    } sweep_t;

    sweep_t              state_q, state_d;
    logic [OP_W-1:0]     idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                overrun_q, overrun_d;
    phase_t              phase_q [NUM_OPS];
    logic [8:0]          level_q [NUM_OPS];
    logic [21:0]         cfg_q   [NUM_OPS];
    logic [NUM_OPS-1:0]  pend_on_q, pend_off_q;
    logic                att_valid_q;
    logic [OP_W-1:0]     att_op_q;
    logic [8:0]          att_level_q;

    logic [14:0]         cnt15_w;
    logic [21:0]         cfg_w;
    phase_t              ph_d;
    logic [8:0]          lv_d;
    logic [8:0]          dec_w;
    logic [9:0]          sum_w;
    logic [8:0]          att_d;
    logic                cfg_ok_w, key_ok_w;

    // Rate division only looks at the low 15 counter bits.
    generate
        if (CNT_W >= 15) begin : g_cnt_trunc
            assign cnt15_w = cnt_q[14:0];
        end else begin : g_cnt_ext
            assign cnt15_w = {{(15-CNT_W){1'b0}}, cnt_q};
        end
    endgenerate

    function automatic logic rate_step(input logic [3:0] r, input logic [14:0] c);
        logic [14:0] mask;
        mask = 15'h7FFF >> r;
        return (r != 4'd0) && ((c & mask) == 15'd0);
    endfunction

    assign cfg_w    = cfg_q[idx_q];
    assign cfg_ok_w = int'(bus.cfg_op) < NUM_OPS;
    assign key_ok_w = int'(bus.key_op) < NUM_OPS;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        overrun_d = overrun_q;
        case (state_q)
            SW_IDLE: begin
                if (bus.sample_strobe) begin
                    state_d = SW_RUN;
                    idx_d   = '0;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            SW_RUN: begin
                if (bus.sample_strobe) overrun_d = 1'b1;
                if (int'(idx_q) == NUM_OPS - 1) state_d = SW_IDLE;
                else                            idx_d   = idx_q + 1'b1;
            end
            default: state_d = SW_IDLE;
        endcase
    end

    // Envelope update for the operator currently selected by idx_q.
    always_comb begin
        ph_d  = phase_q[idx_q];
        lv_d  = level_q[idx_q];
        dec_w = 9'd0;
        if (pend_on_q[idx_q])                             ph_d = PH_ATTACK;
        else if (pend_off_q[idx_q] && ph_d != PH_IDLE)    ph_d = PH_RELEASE;
        case (ph_d)
            PH_ATTACK: begin
                if (cfg_w[15:12] == 4'd15) begin
                    lv_d = 9'd0;
                end else if (rate_step(cfg_w[15:12], cnt15_w)) begin
                    dec_w = (lv_d >> 3) + 9'd1;
                    lv_d  = (lv_d > dec_w) ? lv_d - dec_w : 9'd0;
                end
                if (lv_d == 9'd0) ph_d = PH_DECAY;
            end
            PH_DECAY: begin
                if (rate_step(cfg_w[11:8], cnt15_w) && lv_d != 9'd511) lv_d = lv_d + 9'd1;
                if (lv_d >= {cfg_w[7:4], 5'b0}) ph_d = PH_SUSTAIN;
            end
            PH_SUSTAIN: begin
                lv_d = level_q[idx_q];
            end
            PH_RELEASE: begin
                if (rate_step(cfg_w[3:0], cnt15_w) && lv_d != 9'd511) lv_d = lv_d + 9'd1;
                if (lv_d == 9'd511) ph_d = PH_IDLE;
            end
            default: begin
                ph_d = PH_IDLE;
                lv_d = 9'd511;
            end
        endcase
        sum_w = {1'b0, lv_d} + {2'b0, cfg_w[21:16], 2'b0};
        att_d = (sum_w > 10'd511) ? 9'd511 : sum_w[8:0];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= SW_IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            overrun_q   <= 1'b0;
            pend_on_q   <= '0;
            pend_off_q  <= '0;
            att_valid_q <= 1'b0;
            att_op_q    <= '0;
            att_level_q <= 9'd511;
            for (int i = 0; i < NUM_OPS; i++) begin
                phase_q[i] <= PH_IDLE;
                level_q[i] <= 9'd511;
                cfg_q[i]   <= '0;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            overrun_q   <= overrun_d;
            att_valid_q <= (state_q == SW_RUN);
            if (state_q == SW_RUN) begin
                phase_q[idx_q]    <= ph_d;
                level_q[idx_q]    <= lv_d;
                pend_on_q[idx_q]  <= 1'b0;
                pend_off_q[idx_q] <= 1'b0;
                att_op_q          <= idx_q;
                att_level_q       <= att_d;
            end
            if (bus.cfg_wr && cfg_ok_w) cfg_q[bus.cfg_op] <= bus.cfg_data;
            // Placed after the sweep clear so a same-cycle key write survives.
            if (bus.key_wr && key_ok_w) begin
                pend_on_q[bus.key_op]  <= bus.key_on;
                pend_off_q[bus.key_op] <= !bus.key_on;
            end
        end
    end

    assign bus.busy      = (state_q == SW_RUN);
    assign bus.att_valid = att_valid_q;
    assign bus.att_op    = att_op_q;
    assign bus.att_level = att_level_q;
    assign bus.overrun   = overrun_q;
endmodule
`default_nettype wire

// File: tb/tb_fm_envgen_mux.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fm_envgen_mux : directed self-checking bench for fm_envgen_mux          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_fm_envgen_mux;
    localparam int NUM_OPS = 8;
    localparam int OP_W    = 3;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   tb_cnt   = 0;

    int   cap_lvl [NUM_OPS];
    int   n_valid, exp_op, first_cyc, strobe_cyc, nb, valid_after;
    bit   seq_err;
    int   lv5;

    fm_envgen_mux_if #(.OP_W(OP_W)) bus ();

    fm_envgen_mux #(.NUM_OPS(NUM_OPS), .OP_W(OP_W), .CNT_W(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (bus.att_valid) begin
            if (n_valid == 0) first_cyc = cyc;
            if (int'(bus.att_op) != exp_op) seq_err = 1'b1;
            exp_op++;
            cap_lvl[bus.att_op] = int'(bus.att_level);
            n_valid++;
        end
    end

    initial begin
        #5000000;
        $display("FAIL timeout: observed no end of test, expected $finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [21:0] mkcfg(input int tl, input int ar, input int dr,
                                          input int sl, input int rr);
        return {tl[5:0], ar[3:0], dr[3:0], sl[3:0], rr[3:0]};
    endfunction

    function automatic int atk(input int lv);
        int d;
        d = (lv >> 3) + 1;
        return (lv > d) ? lv - d : 0;
    endfunction

    function automatic int min511(input int v);
        return (v > 511) ? 511 : v;
    endfunction

    task automatic cfg_key(input int op, input logic [21:0] d, input logic on);
        @(negedge clk);
        bus.cfg_wr = 1'b1; bus.cfg_op = op[OP_W-1:0]; bus.cfg_data = d;
        bus.key_wr = 1'b1; bus.key_op = op[OP_W-1:0]; bus.key_on = on;
        @(negedge clk);
        bus.cfg_wr = 1'b0; bus.key_wr = 1'b0;
    endtask

    task automatic key_only(input int op, input logic on);
        @(negedge clk);
        bus.key_wr = 1'b1; bus.key_op = op[OP_W-1:0]; bus.key_on = on;
        @(negedge clk);
        bus.key_wr = 1'b0;
    endtask

    // One sweep; optionally a key write or a second strobe at a cycle offset.
    task automatic sweep_x(input bit kdo, input int kop, input logic kon, input int koff,
                           input bit sdo, input int soff);
        @(negedge clk);
        for (int k = 0; k < NUM_OPS; k++) cap_lvl[k] = -1;
        n_valid = 0; exp_op = 0; seq_err = 1'b0; first_cyc = -1;
        strobe_cyc = cyc + 1;
        bus.sample_strobe = 1'b1;
        @(negedge clk);
        bus.sample_strobe = 1'b0;
        nb = 0;
        while (bus.busy && nb < 100) begin
            if (kdo && cyc == strobe_cyc + koff) begin
                bus.key_wr = 1'b1; bus.key_op = kop[OP_W-1:0]; bus.key_on = kon;
            end
            if (sdo && cyc == strobe_cyc + soff) bus.sample_strobe = 1'b1;
            @(negedge clk);
            bus.key_wr = 1'b0; bus.sample_strobe = 1'b0;
            nb++;
        end
        @(negedge clk);
        valid_after = int'(bus.att_valid);
        tb_cnt++;
    endtask

    task automatic sweep();
        sweep_x(1'b0, 0, 1'b0, 0, 1'b0, 0);
    endtask

    task automatic chk_timing(input string tag);
        chk({tag, "_busy_len"}, nb, NUM_OPS);
        chk({tag, "_first_valid"}, first_cyc - strobe_cyc, 1);
        chk({tag, "_n_valid"}, n_valid, NUM_OPS);
        chk({tag, "_op_seq"}, seq_err, 0);
        chk({tag, "_valid_after"}, valid_after, 0);
    endtask

    initial begin
        bus.cfg_wr = 1'b0; bus.cfg_op = '0; bus.cfg_data = '0;
        bus.key_wr = 1'b0; bus.key_op = '0; bus.key_on = 1'b0;
        bus.sample_strobe = 1'b0;

        // Reset values
        repeat (5) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_att_valid", bus.att_valid, 0);
        chk("rst_att_op", bus.att_op, 0);
        chk("rst_att_level", bus.att_level, 511);
        chk("rst_overrun", bus.overrun, 0);
        reset = 1'b1;

        sweep();
        chk_timing("rst_sweep");
        for (int k = 0; k < NUM_OPS; k++) chk($sformatf("rst_lvl_op%0d", k), cap_lvl[k], 511);

        // Instant attack on op2, DR=0 holds the level
        cfg_key(2, mkcfg(0, 15, 0, 7, 9), 1'b1);
        sweep();
        chk_timing("inst_sweep");
        chk("inst_op2", cap_lvl[2], 0);
        chk("inst_op0_idle", cap_lvl[0], 511);
        for (int i = 0; i < 100; i++) begin
            sweep();
            chk("inst_hold_op2", cap_lvl[2], 0);
        end

        // Full envelope on op0
        cfg_key(0, mkcfg(0, 15, 15, 1, 15), 1'b1);
        for (int i = 1; i <= 35; i++) begin
            sweep();
            chk($sformatf("env_ad_%0d", i), cap_lvl[0], (i - 1 < 32) ? i - 1 : 32);
        end
        key_only(0, 1'b0);
        for (int j = 1; j <= 481; j++) begin
            sweep();
            chk($sformatf("env_rel_%0d", j), cap_lvl[0], min511(32 + j));
        end
        chk("env_op2_still0", cap_lvl[2], 0);

        // TL saturation on op1
        cfg_key(1, mkcfg(63, 15, 0, 0, 15), 1'b1);
        sweep();
        chk("tl_full", cap_lvl[1], 252);
        key_only(1, 1'b0);
        for (int n = 1; n <= 300; n++) begin
            sweep();
            chk($sformatf("tl_rel_%0d", n), cap_lvl[1], min511(n + 252));
        end

        // Key race on op3
        cfg_key(3, mkcfg(0, 15, 0, 0, 15), 1'b1);
        sweep();
        chk("race_setup_op3", cap_lvl[3], 0);
        sweep_x(1'b1, 3, 1'b0, 3, 1'b0, 0);
        chk_timing("race_sweep");
        chk("race_same_cycle_op3", cap_lvl[3], 0);
        sweep();
        chk("race_next_sweep_op3", cap_lvl[3], 1);
        key_only(3, 1'b1);
        key_only(3, 1'b0);
        sweep();
        chk("race_last_wins_op3", cap_lvl[3], 2);

        // Overrun: second strobe 3 cycles after the first, op5 tracks counter parity
        cfg_key(5, mkcfg(0, 14, 0, 0, 0), 1'b1);
        lv5 = 511;
        sweep_x(1'b0, 0, 1'b0, 0, 1'b1, 2);
        chk_timing("ovr_sweep");
        if ((tb_cnt & 1) == 0) lv5 = atk(lv5);
        chk("ovr_flag", bus.overrun, 1);
        chk("ovr_op5_lvl", cap_lvl[5], lv5);
        sweep();
        if ((tb_cnt & 1) == 0) lv5 = atk(lv5);
        chk("ovr_op5_lvl2", cap_lvl[5], lv5);
        chk("ovr_sticky", bus.overrun, 1);

        // Reset mid-sweep
        @(negedge clk);
        bus.sample_strobe = 1'b1;
        @(negedge clk);
        bus.sample_strobe = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_busy_before", bus.busy, 1);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_valid", bus.att_valid, 0);
        chk("mid_rst_level", bus.att_level, 511);
        chk("mid_rst_overrun", bus.overrun, 0);
        reset = 1'b1;
        tb_cnt = 0;
        @(negedge clk);
        chk("mid_abort_busy", bus.busy, 0);
        chk("mid_abort_valid", bus.att_valid, 0);
        sweep();
        chk_timing("post_rst_sweep");
        chk("post_rst_op2", cap_lvl[2], 511);
        chk("post_rst_op3", cap_lvl[3], 511);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
